// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 emulator: FSM states, protocol phase
// lengths in microseconds and small helpers used by the top.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_DELAY,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } state_t;

  localparam int T_ACK_LOW_US   = 80;
  localparam int T_ACK_HIGH_US  = 80;
  localparam int T_BIT_LOW_US   = 50;
  localparam int T_BIT0_HIGH_US = 27;
  localparam int T_BIT1_HIGH_US = 70;
  localparam int T_END_LOW_US   = 50;
  localparam int FRAME_BITS     = 40;

  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  // Phases in which the emulator pulls the bus low.
  function automatic logic drives_low(input state_t s);
    return (s == ST_ACK_LOW) || (s == ST_BIT_LOW) || (s == ST_END_LOW);
  endfunction

endpackage

// File: rtl/gerador_tick_us.sv
// Restartable microsecond prescaler: one-cycle tick every CLKS_PER_US clocks,
// counting from zero again whenever restart is asserted.
module gerador_tick_us #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CW'(CLKS_PER_US - 1));

endmodule

// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator: accepts a host start pulse on the open-drain line,
// answers with the acknowledge sequence and a 40-bit humidity/temperature frame.
module dht11_emulador
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         transmission_line,
  input  logic        present,
  input  logic [7:0]  hum_int,
  input  logic [7:0]  hum_dec,
  input  logic [7:0]  temp_int,
  input  logic [7:0]  temp_dec,
  input  logic        inject_checksum_error,
  output logic        drive_low,
  output logic        busy,
  output logic        start_detected,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int US_W        = $clog2(START_MIN_US + RESP_DELAY_US + 256) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_sync;
  logic              w_line_s;
  logic              w_tick;
  logic              w_restart;
  logic [US_W-1:0]   r_us;
  logic [US_W-1:0]   w_host_us;
  logic [US_W-1:0]   w_phase_len;
  logic              w_phase_done;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]        r_bit_cnt;
  logic              r_drive_low;
  logic [15:0]       r_frames;
  logic              w_load;
  logic              w_shift;
  logic              w_start;
  logic              w_done;

  // Two-flop synchronizer; idles high so reset never looks like a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], transmission_line};
    end
  end
  assign w_line_s = r_sync[1];

  assign w_restart = (w_state_next != r_state);

  gerador_tick_us #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(w_restart),
    .tick   (w_tick)
  );

  // Microseconds elapsed in the current phase; saturates while timing the host low.
  always_ff @(posedge clock) begin
    if (reset || w_restart) begin
      r_us <= '0;
    end else if (w_tick) begin
      if (r_state == ST_HOST_LOW) begin
        if (r_us < US_W'(START_MIN_US)) r_us <= r_us + 1'b1;
      end else if (r_state != ST_IDLE) begin
        r_us <= r_us + 1'b1;
      end
    end
  end

  // Includes the microsecond completing in the current cycle.
  assign w_host_us = r_us + {{(US_W-1){1'b0}}, w_tick};

  always_comb begin
    w_phase_len = US_W'(1);
    case (r_state)
      ST_RESP_DELAY: w_phase_len = US_W'(RESP_DELAY_US);
      ST_ACK_LOW:    w_phase_len = US_W'(T_ACK_LOW_US);
      ST_ACK_HIGH:   w_phase_len = US_W'(T_ACK_HIGH_US);
      ST_BIT_LOW:    w_phase_len = US_W'(T_BIT_LOW_US);
      ST_BIT_HIGH:   w_phase_len = r_shift[FRAME_BITS-1] ? US_W'(T_BIT1_HIGH_US)
                                                         : US_W'(T_BIT0_HIGH_US);
      ST_END_LOW:    w_phase_len = US_W'(T_END_LOW_US);
      default:       w_phase_len = US_W'(1);
    endcase
  end

  assign w_phase_done = w_tick && (r_us == w_phase_len - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_line_s) w_state_next = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (w_line_s) begin
          if ((w_host_us >= US_W'(START_MIN_US)) && present) begin
            w_load       = 1'b1;
            w_start      = 1'b1;
            w_state_next = ST_RESP_DELAY;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_RESP_DELAY: if (w_phase_done) w_state_next = ST_ACK_LOW;
      ST_ACK_LOW:    if (w_phase_done) w_state_next = ST_ACK_HIGH;
      ST_ACK_HIGH:   if (w_phase_done) w_state_next = ST_BIT_LOW;
      ST_BIT_LOW:    if (w_phase_done) w_state_next = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (w_phase_done) begin
          w_shift      = 1'b1;
          w_state_next = (r_bit_cnt == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
        end
      end
      ST_END_LOW: begin
        if (w_phase_done) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_drive_low <= 1'b0;
      r_frames    <= '0;
    end else begin
      r_drive_low <= drives_low(r_state);
      if (w_load) begin
        r_shift   <= {hum_int, hum_dec, temp_int, temp_dec,
                      checksum(hum_int, hum_dec, temp_int, temp_dec) ^ {7'd0, inject_checksum_error}};
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (w_done) r_frames <= r_frames + 16'd1;
    end
  end

  assign transmission_line = r_drive_low ? 1'b0 : 1'bz;
  assign drive_low         = r_drive_low;
  assign start_detected    = w_start;
  assign frame_done        = w_done;
  assign frames_sent       = r_frames;
  assign busy              = w_start ||
                             (((r_state == ST_RESP_DELAY) || (r_state == ST_ACK_LOW) ||
                               (r_state == ST_ACK_HIGH)   || (r_state == ST_BIT_LOW) ||
                               (r_state == ST_BIT_HIGH)   || (r_state == ST_END_LOW)) && !w_done);

endmodule

// File: tb/tb_dht11_emulador.sv
// Scoreboard bench for dht11_emulador: stimulus queues expected frames,
// a monitor decodes the pull-down waveform and compares on each completed frame.
module tb_dht11_emulador;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        present = 1'b1;
  logic        inj = 1'b0;
  logic        host_low = 1'b0;
  logic [7:0]  hi = 8'h00, hd = 8'h00, ti = 8'h00, td = 8'h00;
  wire         line;
  logic        drive_low, busy, start_detected, frame_done;
  logic [15:0] frames_sent;

  pullup (line);
  assign line = host_low ? 1'b0 : 1'bz;

  dht11_emulador #(
    .CLK_FREQ_HZ  (1_000_000),
    .START_MIN_US (18),
    .RESP_DELAY_US(30)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .transmission_line    (line),
    .present              (present),
    .hum_int              (hi),
    .hum_dec              (hd),
    .temp_int             (ti),
    .temp_dec             (td),
    .inject_checksum_error(inj),
    .drive_low            (drive_low),
    .busy                 (busy),
    .start_detected       (start_detected),
    .frame_done           (frame_done),
    .frames_sent          (frames_sent)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int mirror_errs = 0;
  int done_count = 0;
  logic [39:0] exp_q[$];

  // Monitor state
  bit   in_frame = 0;
  bit   pending = 0;
  logic prev_drive = 1'b0;
  int   run_len = 0;
  int   runs[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference frame straight from the protocol rules.
  function automatic logic [39:0] model_frame(input int a, input int b, input int c,
                                              input int d, input int e);
    int s;
    s = (a + b + c + d) % 256;
    if (e != 0) s = s ^ 1;
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(s)};
  endfunction

  task automatic evaluate();
    logic [39:0] got;
    logic [39:0] exp;
    int bad_low;
    int bad_high;
    got = '0;
    bad_low = 0;
    bad_high = 0;
    check("run_count", runs.size(), 84);
    if (runs.size() == 84) begin
      check("ack_low_us", runs[1], 80);
      check("ack_high_us", runs[2], 80);
      for (int i = 0; i < 40; i++) begin
        if (runs[3 + 2*i] != 50) bad_low++;
        if (runs[4 + 2*i] == 70)      got = {got[38:0], 1'b1};
        else if (runs[4 + 2*i] == 27) got = {got[38:0], 1'b0};
        else begin
          bad_high++;
          got = {got[38:0], 1'b0};
        end
      end
      check("bit_low_bad_count", bad_low, 0);
      check("bit_high_bad_count", bad_high, 0);
      check("end_low_us", runs[83], 50);
    end
    done_count++;
    check("frames_sent", frames_sent, done_count);
    if (exp_q.size() == 0) begin
      check("frame_expected", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      $display("frame %0d: decoded %010h expected %010h", done_count, got, exp);
      check("frame_data", got, exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        in_frame   = 0;
        pending    = 0;
        done_count = 0;
        runs.delete();
      end else begin
        if (start_detected) begin
          if (in_frame) check("no_restart_mid_frame", 1, 0);
          in_frame   = 1;
          pending    = 0;
          runs.delete();
          prev_drive = drive_low;
          run_len    = 0;
        end
        if (in_frame) begin
          if (drive_low != prev_drive) begin
            runs.push_back(run_len);
            run_len    = 0;
            prev_drive = drive_low;
            if (pending && !drive_low) begin
              evaluate();
              in_frame = 0;
            end
          end
          run_len++;
          if (frame_done) pending = 1;
        end
      end
      if (!host_low && (line !== (drive_low ? 1'b0 : 1'b1))) mirror_errs++;
    end
  end

  task automatic host_pulse(input int us);
    @(negedge clock);
    host_low = 1'b1;
    repeat (us) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic valid_start(input int us, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input logic e);
    int lat;
    @(negedge clock);
    hi = a; hd = b; ti = c; td = d; inj = e;
    exp_q.push_back(model_frame(a, b, c, d, e));
    host_pulse(us);
    lat = 0;
    while (!start_detected && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("start_latency", lat, 2);
  endtask

  task automatic wait_frame();
    int cyc;
    cyc = 0;
    while (!frame_done && cyc < 8000) begin
      @(negedge clock);
      cyc++;
    end
    check("frame_done_seen", frame_done, 1);
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_lows(input int n);
    int cnt;
    int cyc;
    logic prev;
    cnt = 0;
    cyc = 0;
    prev = drive_low;
    while (cnt < n && cyc < 8000) begin
      @(negedge clock);
      cyc++;
      if (drive_low && !prev) cnt++;
      prev = drive_low;
    end
    if (cnt != n) check("wait_lows_reached", cnt, n);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic saw_busy, saw_drive, saw_start;
    saw_busy = 0; saw_drive = 0; saw_start = 0;
    repeat (cycles) begin
      @(negedge clock);
      saw_busy  |= busy;
      saw_drive |= drive_low;
      saw_start |= start_detected;
    end
    check({tag, "_busy"}, saw_busy, 0);
    check({tag, "_drive"}, saw_drive, 0);
    check({tag, "_start"}, saw_start, 0);
  endtask

  initial begin : stimulus
    logic [15:0] fs_before;
    logic        saw_done;
    repeat (3) @(negedge clock);
    check("rst_drive_low", drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_start_detected", start_detected, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_line", line, 1);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Reference frame 0x37_00_19_00_50
    valid_start(20, 8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    wait_frame();

    host_pulse(10);
    expect_silence("short10", 60);
    host_pulse(17);
    expect_silence("short17", 60);

    valid_start(18, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
    wait_frame();

    // Checksum 0xFC inverted in LSB -> 0xFD
    valid_start(20, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    wait_frame();
    inj = 1'b0;

    present = 1'b0;
    fs_before = frames_sent;
    host_pulse(20);
    expect_silence("absent", 200);
    check("absent_frames_sent", frames_sent, fs_before);
    present = 1'b1;

    // Payload change, present drop and a host start during bit 5
    valid_start(22, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
    wait_lows(6);
    repeat (20) @(negedge clock);
    hi = 8'($urandom_range(255, 0)); hd = 8'($urandom_range(255, 0));
    ti = 8'($urandom_range(255, 0)); td = 8'($urandom_range(255, 0));
    inj = 1'b1;
    present = 1'b0;
    host_pulse(20);
    wait_frame();
    present = 1'b1;
    inj = 1'b0;

    // Reset during bit 12
    valid_start(20, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
    wait_lows(13);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_releases_drive", drive_low, 0);
    check("reset_releases_line", line, 1);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    exp_q.delete();
    saw_done = 0;
    repeat (200) begin
      @(negedge clock);
      saw_done |= frame_done;
    end
    check("no_done_after_reset", saw_done, 0);
    check("frames_sent_after_reset", frames_sent, 0);
    valid_start(20, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
    wait_frame();

    for (int k = 0; k < 3; k++) begin
      valid_start(int'($urandom_range(25, 18)), 8'($urandom_range(255, 0)),
                  8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                  8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      wait_frame();
    end

    check("line_mirror_errors", mirror_errs, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
